// File: rtl/umem_arbiter.sv
// Unified-memory arbiter: one single-ported memory shared by fetch and data.
// Data wins by default; a streak counter hands the next slot to a waiting fetch.
module umem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          pcrst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int DSW = $clog2(STARVE + 1);
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DSW-1:0] SMAX = DSW'(STARVE);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q;
  logic            own_dm_q;
  logic [DSW-1:0]  dstreak_q;
  logic [DSW-1:0]  dstreak_d;
  logic [CW-1:0]   cnt_q;
  logic            m_en_q;
  logic            m_we_q;
  logic [AW-1:0]   m_addr_q;
  logic [DW-1:0]   m_wdata_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   dm_rdata_q;
  logic            if_done_q;
  logic            dm_done_q;
  logic            any_req;
  logic            pick_dm;

  always_comb begin
    any_req   = if_req | dm_req;
    pick_dm   = dm_req & ~(if_req & (dstreak_q == SMAX));
    dstreak_d = '0;
    if (pick_dm && if_req) begin
      dstreak_d = (dstreak_q == SMAX) ? SMAX
                                      : dstreak_q + DSW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pcrst) begin
      state_q    <= IDLE;
      own_dm_q   <= 1'b0;
      dstreak_q  <= '0;
      cnt_q      <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= ISSUE;
            m_en_q    <= 1'b1;
            own_dm_q  <= pick_dm;
            dstreak_q <= dstreak_d;
            if (pick_dm) begin
              m_we_q    <= dm_we;
              m_addr_q  <= dm_addr;
              m_wdata_q <= dm_wdata;
            end else begin
              m_we_q   <= 1'b0;
              m_addr_q <= if_addr;
            end
          end
        end
        ISSUE: begin
          m_en_q <= 1'b0;
          m_we_q <= 1'b0;
          if (m_we_q) begin
            state_q   <= RESP;
            dm_done_q <= own_dm_q;
            if_done_q <= ~own_dm_q;
          end else begin
            cnt_q   <= CW'(LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // cnt reaches zero in the cycle m_rdata is valid
          if (cnt_q == '0) begin
            state_q <= RESP;
            if (own_dm_q) begin
              dm_rdata_q <= m_rdata;
              dm_done_q  <= 1'b1;
            end else begin
              if_rdata_q <= m_rdata;
              if_done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if_done_q <= 1'b0;
          dm_done_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;
  assign if_stall = if_req & ~if_done_q;
  assign dm_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_umem_arbiter.sv
// Bench for umem_arbiter: latency-accurate memory model, table vectors,
// hand sequences for corner cases and a randomized arbitration model.
module tb_umem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          pcrst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_stall;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  umem_arbiter #(
    .AW(AW), .DW(DW), .LAT(LAT), .STARVE(STARVE)
  ) dut (
    .clk(clk), .pcrst(pcrst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 'h40) ? 32'h2002000A : (32'hC0DE0000 | 32'(i));
  endfunction

  // memory: data valid exactly LAT cycles after a read strobe, junk otherwise
  logic [31:0] mem [256];
  bit          mem_ready;
  bit          pv [LAT];
  logic [31:0] pd [LAT];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (m_en && m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
    pv[0] <= m_en && !m_we;
    pd[0] <= mem[m_addr[9:2]];
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign m_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAADF00D;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] ref_mem [256];
  int          streak;
  logic [31:0] last_if;
  logic [31:0] last_dm;
  bit          scramble;

  // One access from the IDLE cycle (inputs already set) to the next IDLE.
  task automatic round(output logic obs_dm, output int obs_lat);
    logic ir, dr, wdm, we;
    logic [31:0] a, wd, exp;
    int lat;
    ir  = if_req;
    dr  = dm_req;
    wdm = dr && !(ir && streak >= STARVE);
    if (wdm && ir) streak = (streak < STARVE) ? streak + 1 : STARVE;
    else streak = 0;
    we  = wdm && dm_we;
    a   = wdm ? dm_addr : if_addr;
    wd  = dm_wdata;
    lat = we ? 2 : LAT + 2;
    exp = ref_mem[a[9:2]];
    if (we) ref_mem[a[9:2]] = wd;
    obs_dm  = 1'b0;
    obs_lat = -1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (obs_lat < 0 && (if_done || dm_done)) begin
        obs_lat = k;
        obs_dm  = dm_done;
      end
      chk("m_en", m_en, k == 1);
      if (k == 1) begin
        chk("m_we", m_we, we);
        chk("m_addr", m_addr, a);
        if (we) chk("m_wdata", m_wdata, wd);
        if (scramble) begin
          if (wdm) begin
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = $urandom_range(1);
          end else begin
            if_addr = $urandom;
          end
        end
      end
      chk("win_done", wdm ? dm_done : if_done, k == lat);
      chk("win_stall", wdm ? dm_stall : if_stall, k < lat);
      chk("lose_done", wdm ? if_done : dm_done, 1'b0);
      chk("lose_stall", wdm ? if_stall : dm_stall, wdm ? ir : dr);
    end
    if (!we) begin
      if (wdm) last_dm = exp;
      else last_if = exp;
    end
    chk("if_rdata", if_rdata, last_if);
    chk("dm_rdata", dm_rdata, last_dm);
    if (wdm) dm_req = 1'b0;
    else if_req = 1'b0;
    @(negedge clk);
    chk("idle_m_en", m_en, 1'b0);
    chk("idle_done", {if_done, dm_done}, 2'b00);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_m_en"}, m_en, 1'b0);
    chk({nm, "_m_we"}, m_we, 1'b0);
    chk({nm, "_m_addr"}, m_addr, 0);
    chk({nm, "_m_wdata"}, m_wdata, 0);
    chk({nm, "_if_rdata"}, if_rdata, 0);
    chk({nm, "_dm_rdata"}, dm_rdata, 0);
    chk({nm, "_dones"}, {if_done, dm_done}, 2'b00);
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        xdm;
    int          xlat;
    logic [31:0] xif;
    logic [31:0] xdmr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic od;
    int   ol;
    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, LAT + 2, 32'h2002000A, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF,
               1'b1, 2, 32'h2002000A, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0,
               1'b1, LAT + 2, 32'h2002000A, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, LAT + 2, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h12345678,
               1'b1, 2, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, LAT + 2, 32'h12345678, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0,
               1'b1, LAT + 2, 32'h12345678, 32'h12345678};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0,
               1'b1, LAT + 2, 32'h12345678, 32'hC0DE0000};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    streak   = 0;
    last_if  = '0;
    last_dm  = '0;
    scramble = 1'b0;

    pcrst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_stall", {if_stall, dm_stall}, 2'b00);
    pcrst = 1'b0;

    // table vectors: single-port accesses, back to back
    for (int i = 0; i < 8; i++) begin
      if_req = tbl[i].ir;  if_addr = tbl[i].ia;
      dm_req = tbl[i].dr;  dm_we = tbl[i].dwe;
      dm_addr = tbl[i].da; dm_wdata = tbl[i].dwd;
      round(od, ol);
      chk("tbl_winner", od, tbl[i].xdm);
      chk("tbl_lat", ol, tbl[i].xlat);
      chk("tbl_if_rdata", if_rdata, tbl[i].xif);
      chk("tbl_dm_rdata", dm_rdata, tbl[i].xdmr);
    end

    // simultaneous reads: data first, fetch in the following slot
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    round(od, ol);
    chk("sim_first_dm", od, 1'b1);
    chk("sim_first_lat", ol, LAT + 2);
    round(od, ol);
    chk("sim_second_dm", od, 1'b0);
    chk("sim_second_lat", ol, LAT + 2);
    chk("sim_if_rdata", if_rdata, 32'hC0DE0080);

    // starvation guard: fetch waits behind a stream of data reads
    if_req = 1'b1; if_addr = 32'h3FC;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
    for (int r = 0; r < 2 * (STARVE + 1); r++) begin
      round(od, ol);
      chk("starve_order", od, (r % (STARVE + 1)) != STARVE);
      if (!dm_req) begin
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'(r) << 2;
      end
      if (!if_req) begin
        if_req = 1'b1; if_addr = 32'h3F0 + (32'(r) << 2);
      end
    end
    if_req = 1'b0;
    round(od, ol);
    chk("starve_tail_dm", od, 1'b1);

    // data write whose req drops right after the grant
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("drop_m_en", m_en, 1'b1);
    chk("drop_m_we", m_we, 1'b1);
    chk("drop_m_addr", m_addr, 32'h300);
    dm_req = 1'b0;
    @(negedge clk);
    chk("drop_done", dm_done, 1'b1);
    chk("drop_stall", dm_stall, 1'b0);
    ref_mem[8'hC0] = 32'hCAFEF00D;
    streak = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drop_no_regrant", {m_en, dm_done}, 2'b00);
    end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    round(od, ol);
    chk("drop_readback", dm_rdata, 32'hCAFEF00D);

    // reset in the middle of a fetch read
    if_req = 1'b1; if_addr = 32'h100;
    repeat (2) @(negedge clk);
    pcrst = 1'b1;
    @(negedge clk);
    pcrst = 1'b0;
    if_req = 1'b0;
    chk_reset_vals("midrst");
    streak = 0; last_if = '0; last_dm = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst_quiet", {m_en, if_done, dm_done}, 3'b000);
    end
    if_req = 1'b1; if_addr = 32'h100;
    round(od, ol);
    chk("midrst_lat", ol, LAT + 2);
    chk("midrst_rdata", if_rdata, 32'h12345678);

    // randomized traffic with post-grant input scrambling
    scramble = 1'b1;
    for (int it = 0; it < 200; it++) begin
      if (!if_req && $urandom_range(1) == 1) begin
        if_req = 1'b1;
        if_addr = 32'($urandom_range(255)) << 2;
      end
      if (!dm_req && $urandom_range(2) != 0) begin
        dm_req = 1'b1;
        dm_we = $urandom_range(1);
        dm_addr = 32'($urandom_range(255)) << 2;
        dm_wdata = $urandom;
      end
      if (if_req || dm_req) round(od, ol);
      else @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Unified-memory arbiter for the pipelined CPU. It shares one single-ported memory between the instruction-fetch port (IF stage) and the data port (MEM stage). Only one access is in flight at a time. Data wins by default, and a starvation guard ensures fetch is eventually served. It produces per-port stall signals so the pipeline registers hold while an access is pending.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.
- `LAT`, 2, memory read latency: cycles from `m_en` to valid `m_rdata`; ≥1.
- `STARVE`, 4, maximum consecutive data grants while fetch waits; ≥1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `pcrst`  in  1  reset; one clock, reset is synchronous and active-high.
- `if_req`  in  1  fetch request; held high until `if_done`.
- `if_addr`  in  AW  fetch address.
- `if_rdata`  out  DW  fetched word, registered.
- `if_done`  out  1  one-cycle completion pulse for the fetch port.
- `if_stall`  out  1  `if_req & ~if_done`.
- `dm_req`  in  1  data request; held high until `dm_done`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  AW  data address.
- `dm_wdata`  in  DW  write data.
- `dm_rdata`  out  DW  read word, registered.
- `dm_done`  out  1  one-cycle completion pulse for the data port.
- `dm_stall`  out  1  `dm_req & ~dm_done`.
- `m_en`  out  1  memory access strobe, asserted for one cycle per access.
- `m_we`  out  1  memory write enable; qualified by `m_en`.
- `m_addr`  out  AW  memory address, registered.
- `m_wdata`  out  DW  memory write data, registered.
- `m_rdata`  in  DW  memory read data; valid exactly `LAT` cycles after `m_en` with `m_we=0`.

## Operation
The arbiter is a four-state FSM: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Requests are sampled only in this state.
  - If any request is present, latch the owner, addr, we and wdata, then go to ISSUE.
  - If no request is present, stay in IDLE.
- **Arbitration**
  - Data wins over fetch.
  - Exception: if `if_req` and `dm_req` are both high and `dstreak == STARVE`, fetch wins.
- **dstreak counter**
  - Width `clog2(STARVE+1)`.
  - Increments on each data grant made while `if_req` is high; saturates at `STARVE`.
  - Cleared on every fetch grant.
  - Cleared on a data grant made while `if_req` is low.
- **ISSUE**
  - Drive `m_en=1`, `m_we` = latched we (always 0 for fetch), and the latched `m_addr`/`m_wdata`.
  - Write: go to RESP.
  - Read: load `cnt = LAT-1`, then go to WAIT.
- **WAIT**
  - Decrement `cnt` each cycle.
  - When `m_rdata` is valid (LAT cycles after ISSUE), capture it into the owner's rdata register and go to RESP.
- **RESP**
  - Pulse the owner's done for one cycle, then go to IDLE.
  - The idle port's outputs are untouched.
- **Ignored changes during an access**
  - Input addr/we/wdata changes after the grant are ignored.
  - A requester dropping req mid-access does not abort it; the access completes and done still pulses.
- **rdata hold**
  - `if_rdata`/`dm_rdata` hold their last read value until the next read completes on that port.
  - Writes never change `dm_rdata`.
- **Reset mid-operation**
  - Any outstanding access is abandoned: no done pulse, and late `m_rdata` is discarded.
  - The FSM returns to IDLE.

## Timing
- **Reset values:** state IDLE; `m_en`, `m_we`, `if_done`, `dm_done` = 0; `m_addr`, `m_wdata`, `if_rdata`, `dm_rdata` = 0; dstreak = 0, cnt = 0.
- **Read sequence:** req seen in IDLE at cycle 0 → ISSUE at cycle 1 → data captured at cycle 1+LAT → done at cycle 2+LAT. Total latency is 2+LAT cycles.
- **Write sequence:** IDLE at cycle 0, ISSUE at cycle 1, done at cycle 2.
- **Back-to-back accesses:** RESP is always followed by one IDLE cycle. The next grant issues in the cycle after that IDLE.
  - Minimum read period: LAT+3 cycles.
  - Minimum write period: 3 cycles.
- **Handshake:** the requester drops or renews req in the cycle after seeing done. Because req is not sampled in RESP, the same access is never re-granted.
- **Stall outputs:** `if_stall`/`dm_stall` are combinational from req and the registered done pulse.
- **Simultaneous events:** when both ports request in the same IDLE cycle, exactly one is granted. The loser keeps stalling and is re-evaluated in the next IDLE.

## Test plan
- **Single fetch read** (LAT=2): mem[0x100]=0x2002000A; `if_req` with addr 0x100 at cycle 0 → `m_en=1`, `m_we=0`, `m_addr=0x100` at cycle 1 → `if_done=1`, `if_rdata=0x2002000A` at cycle 4; `if_stall` high in cycles 0–3, low at cycle 4.
- **Data write then read:** `dm_req`, we=1, addr 0x40, wdata 0xDEADBEEF at cycle 0 → `m_en`&`m_we` at cycle 1, `dm_done` at cycle 2, `dm_rdata` still 0. A read of 0x40 starting at cycle 3 → `dm_done` at cycle 7 with `dm_rdata=0xDEADBEEF`.
- **Simultaneous reads at cycle 0:** data granted first, `dm_done` at cycle 4. Fetch issues at cycle 6 and gets `if_done` at cycle 9; `if_stall` high in cycles 0–8.
- **Starvation guard** (STARVE=4): `if_req` held high while `dm_req` presents continuous new reads → exactly 4 data completions, then the 5th grant goes to fetch. After the fetch completes, data is served again and dstreak restarts at 0.
- **Reset mid-read:** `pcrst` pulsed at cycle 2 of a fetch read → no `if_done`, `m_en=0`, all outputs at reset values. A new request after reset completes with normal 2+LAT latency.
- **Req dropped mid-access:** `dm_req` write deasserted at cycle 1 → memory write still issued at cycle 1, `dm_done` still pulses at cycle 2, and no further grant follows.
